// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck core: opcode bytes, fetch-controller
// states and bracket-scan helpers.
package bf_pkg;

    localparam int OPCODE_W = 8;

    localparam logic [OPCODE_W-1:0] OP_INC   = 8'h2B;
    localparam logic [OPCODE_W-1:0] OP_DEC   = 8'h2D;
    localparam logic [OPCODE_W-1:0] OP_LEFT  = 8'h3C;
    localparam logic [OPCODE_W-1:0] OP_RIGHT = 8'h3E;
    localparam logic [OPCODE_W-1:0] OP_OUT   = 8'h2E;
    localparam logic [OPCODE_W-1:0] OP_IN    = 8'h2C;
    localparam logic [OPCODE_W-1:0] OP_LOOP  = 8'h5B;
    localparam logic [OPCODE_W-1:0] OP_END   = 8'h5D;
    localparam logic [OPCODE_W-1:0] OP_NULL  = 8'h00;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_LOAD,
        ST_PRESENT,
        ST_SCAN_ADDR,
        ST_SCAN_CHK,
        ST_HALT,
        ST_ERROR
    } fetch_state_t;

    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } scan_dir_t;

    // "Opening" means the bracket that nests deeper in the scan direction.
    function automatic logic is_open(input logic [OPCODE_W-1:0] op, input scan_dir_t dir);
        return (dir == DIR_FWD) ? (op == OP_LOOP) : (op == OP_END);
    endfunction

    function automatic logic is_close(input logic [OPCODE_W-1:0] op, input scan_dir_t dir);
        return (dir == DIR_FWD) ? (op == OP_END) : (op == OP_LOOP);
    endfunction

endpackage

// File: rtl/bf_fetch_ctrl_if.sv
// ROM read port and execute-unit handshake of the fetch controller.
interface bf_fetch_ctrl_if
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [OPCODE_W-1:0]   rom_data;
    logic [OPCODE_W-1:0]   instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  jump_fwd;
    logic                  jump_back;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr,
        output instr_valid,
        input  instr_ready,
        input  jump_fwd,
        input  jump_back
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr,
        input  instr_valid,
        output instr_ready,
        output jump_fwd,
        output jump_back
    );
endinterface

// File: rtl/bf_nest_counter.sv
// Bracket nesting-depth counter: clear, load-to-1, increment and decrement,
// with zero and about-to-overflow flags.
module bf_nest_counter #(
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clr,
    input  logic                   load1,
    input  logic                   inc,
    input  logic                   dec,
    output logic [DEPTH_WIDTH-1:0] depth,
    output logic                   zero,
    output logic                   ovf
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth <= '0;
        end else if (clr) begin
            depth <= '0;
        end else if (load1) begin
            depth <= DEPTH_WIDTH'(1);
        end else if (inc) begin
            depth <= depth + DEPTH_WIDTH'(1);
        end else if (dec) begin
            depth <= depth - DEPTH_WIDTH'(1);
        end
    end

    assign zero = (depth == '0);
    // Flags that one more increment would wrap.
    assign ovf  = (depth == '1);

endmodule

// File: rtl/bf_fetch_ctrl.sv
// Instruction fetch and bracket-scan controller: walks the program ROM,
// presents opcodes over valid/ready and resolves [ ] jumps by scanning.
module bf_fetch_ctrl
    import bf_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                restart,
    bf_fetch_ctrl_if.master     bus,
    output logic                halted,
    output logic                error
);

    localparam logic [ADDR_WIDTH-1:0] PC_MAX = '1;

    fetch_state_t          state, state_d;
    scan_dir_t             dir, dir_d;
    logic [ADDR_WIDTH-1:0] pc, pc_d;
    logic [OPCODE_W-1:0]   instr_q, instr_d;

    logic                   cnt_clr, cnt_load1, cnt_inc, cnt_dec;
    logic [DEPTH_WIDTH-1:0] depth;
    logic                   depth_zero, depth_ovf, depth_last;
    logic                   at_edge;
    logic [ADDR_WIDTH-1:0]  pc_step;

    bf_nest_counter #(
        .DEPTH_WIDTH(DEPTH_WIDTH)
    ) u_nest (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (cnt_clr),
        .load1  (cnt_load1),
        .inc    (cnt_inc),
        .dec    (cnt_dec),
        .depth  (depth),
        .zero   (depth_zero),
        .ovf    (depth_ovf)
    );

    assign depth_last = (depth == DEPTH_WIDTH'(1));
    assign at_edge    = (dir == DIR_FWD) ? (pc == PC_MAX) : (pc == '0);
    assign pc_step    = (dir == DIR_FWD) ? (pc + ADDR_WIDTH'(1)) : (pc - ADDR_WIDTH'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_FETCH;
            dir     <= DIR_FWD;
            pc      <= '0;
            instr_q <= '0;
        end else begin
            state   <= state_d;
            dir     <= dir_d;
            pc      <= pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d   = state;
        dir_d     = dir;
        pc_d      = pc;
        instr_d   = instr_q;
        cnt_clr   = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        cnt_dec   = 1'b0;

        if (restart) begin
            state_d = ST_FETCH;
            pc_d    = '0;
            cnt_clr = 1'b1;
        end else begin
            unique case (state)
                ST_FETCH: state_d = ST_LOAD;

                ST_LOAD: begin
                    instr_d = bus.rom_data;
                    state_d = (bus.rom_data == OP_NULL) ? ST_HALT : ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (bus.instr_ready) begin
                        if (instr_q == OP_LOOP && bus.jump_fwd) begin
                            cnt_load1 = 1'b1;
                            dir_d     = DIR_FWD;
                            if (pc == PC_MAX) begin
                                state_d = ST_ERROR;
                            end else begin
                                pc_d    = pc + ADDR_WIDTH'(1);
                                state_d = ST_SCAN_ADDR;
                            end
                        end else if (instr_q == OP_END && bus.jump_back) begin
                            cnt_load1 = 1'b1;
                            dir_d     = DIR_BACK;
                            if (pc == '0) begin
                                state_d = ST_ERROR;
                            end else begin
                                pc_d    = pc - ADDR_WIDTH'(1);
                                state_d = ST_SCAN_ADDR;
                            end
                        end else if (pc == PC_MAX) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d    = pc + ADDR_WIDTH'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end

                ST_SCAN_ADDR: state_d = ST_SCAN_CHK;

                ST_SCAN_CHK: begin
                    if (depth_zero) begin
                        state_d = ST_ERROR;
                    end else if (dir == DIR_FWD && bus.rom_data == OP_NULL) begin
                        state_d = ST_ERROR;
                    end else if (is_open(bus.rom_data, dir)) begin
                        if (depth_ovf || at_edge) begin
                            state_d = ST_ERROR;
                        end else begin
                            cnt_inc = 1'b1;
                            pc_d    = pc_step;
                            state_d = ST_SCAN_ADDR;
                        end
                    end else if (is_close(bus.rom_data, dir)) begin
                        cnt_dec = 1'b1;
                        if (depth_last) begin
                            // A match on the last ROM byte leaves nothing to run.
                            if (dir == DIR_FWD && pc == PC_MAX) begin
                                state_d = ST_HALT;
                            end else begin
                                pc_d    = pc + ADDR_WIDTH'(1);
                                state_d = ST_FETCH;
                            end
                        end else if (at_edge) begin
                            state_d = ST_ERROR;
                        end else begin
                            pc_d    = pc_step;
                            state_d = ST_SCAN_ADDR;
                        end
                    end else if (at_edge) begin
                        state_d = ST_ERROR;
                    end else begin
                        pc_d    = pc_step;
                        state_d = ST_SCAN_ADDR;
                    end
                end

                ST_HALT:  state_d = ST_HALT;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_ERROR;
            endcase
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == ST_PRESENT);
    assign halted          = (state == ST_HALT);
    assign error           = (state == ST_ERROR);

endmodule

// File: tb/tb_bf_fetch_ctrl.sv
// Directed bench for bf_fetch_ctrl with a synchronous ROM model and
// hand-computed cycle-by-cycle expectations.
module tb_bf_fetch_ctrl;
    import bf_pkg::*;

    logic clk;
    logic reset_n;
    logic restart;
    logic halted;
    logic error;

    logic [7:0] rom [16];
    int checks;
    int errors;
    int cyc;
    int n;

    bf_fetch_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    bf_fetch_ctrl #(
        .ADDR_WIDTH (4),
        .DEPTH_WIDTH(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .restart(restart),
        .bus    (bus.master),
        .halted (halted),
        .error  (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Steps at least once, then until instr_valid; n is the cycles elapsed.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.instr_valid && cnt < 64);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = OP_NULL;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        restart = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
    endtask

    logic [7:0] exp1 [4];

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        reset_n = 1'b0;
        restart = 1'b0;
        bus.instr_ready = 1'b1;
        bus.jump_fwd = 1'b0;
        bus.jump_back = 1'b0;
        exp1 = '{8'h2B, 8'h2B, 8'h2D, 8'h2D};

        // ++-- then 0x00, ready high
        clear_rom();
        rom[0] = OP_INC; rom[1] = OP_INC; rom[2] = OP_DEC; rom[3] = OP_DEC;
        do_reset();
        chk("rst_instr", bus.instr, 8'h00);
        chk("rst_error", error, 1'b0);
        for (int c = 0; c <= 14; c++) begin
            chk("seq_valid", bus.instr_valid, (c == 2 || c == 5 || c == 8 || c == 11));
            if (c % 3 == 0 && c <= 12) chk("seq_addr", bus.rom_addr, c / 3);
            if (c == 2 || c == 5 || c == 8 || c == 11) chk("seq_instr", bus.instr, exp1[(c - 2) / 3]);
            chk("seq_halted", halted, (c == 14));
            if (c < 14) step();
        end

        // Same program, 5-cycle stall; jump requests on non-brackets are ignored
        bus.instr_ready = 1'b0;
        bus.jump_fwd = 1'b1;
        bus.jump_back = 1'b1;
        do_reset();
        wait_valid(n);
        chk("stall_lat", n, 2);
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", bus.instr_valid, 1'b1);
            chk("stall_instr", bus.instr, 8'h2B);
            step();
        end
        bus.instr_ready = 1'b1;
        chk("stall_rel_valid", bus.instr_valid, 1'b1);
        for (int k = 1; k < 4; k++) begin
            wait_valid(n);
            chk("stall_gap", n, 3);
            chk("stall_seq", bus.instr, exp1[k]);
        end
        step(); step();
        chk("stall_nohalt", halted, 1'b0);
        step();
        chk("stall_halt", halted, 1'b1);

        // Forward scan over [+[-]+]>
        clear_rom();
        rom[0] = OP_LOOP; rom[1] = OP_INC; rom[2] = OP_LOOP; rom[3] = OP_DEC;
        rom[4] = OP_END;  rom[5] = OP_INC; rom[6] = OP_END;  rom[7] = OP_RIGHT;
        bus.jump_fwd = 1'b1;
        bus.jump_back = 1'b0;
        do_reset();
        wait_valid(n);
        chk("fwd_first", bus.instr, 8'h5B);
        step();
        bus.jump_fwd = 1'b0;
        chk("fwd_scan_addr", bus.rom_addr, 1);
        for (int a = 2; a <= 6; a++) begin
            step();
            chk("fwd_scan_nov", bus.instr_valid, 1'b0);
            step();
            chk("fwd_scan_addr", bus.rom_addr, a);
        end
        wait_valid(n);
        chk("fwd_tgt_lat", n, 4);
        chk("fwd_tgt_instr", bus.instr, 8'h3E);
        chk("fwd_tgt_addr", bus.rom_addr, 7);
        chk("fwd_noerr", error, 1'b0);

        // Backward scan over +[-]
        clear_rom();
        rom[0] = OP_INC; rom[1] = OP_LOOP; rom[2] = OP_DEC; rom[3] = OP_END;
        bus.jump_back = 1'b1;
        do_reset();
        wait_valid(n);
        chk("bk_0", bus.instr, 8'h2B);
        wait_valid(n);
        chk("bk_1_gap", n, 3);
        chk("bk_1", bus.instr, 8'h5B);
        wait_valid(n);
        chk("bk_2_gap", n, 3);
        wait_valid(n);
        chk("bk_3_gap", n, 3);
        chk("bk_3", bus.instr, 8'h5D);
        step();
        chk("bk_scan_a2", bus.rom_addr, 2);
        step(); step();
        chk("bk_scan_a1", bus.rom_addr, 1);
        bus.jump_back = 1'b0;
        wait_valid(n);
        chk("bk_tgt_lat", n, 4);
        chk("bk_tgt_instr", bus.instr, 8'h2D);
        chk("bk_tgt_addr", bus.rom_addr, 2);
        wait_valid(n);
        chk("bk_end", bus.instr, 8'h5D);
        step(); step(); step();
        chk("bk_halt", halted, 1'b1);

        // Restart from HALT
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_halt_clr", halted, 1'b0);
        chk("rs_halt_addr", bus.rom_addr, 0);
        wait_valid(n);
        chk("rs_halt_lat", n, 2);
        chk("rs_halt_instr", bus.instr, 8'h2B);

        // Unmatched [+ then 0x00
        clear_rom();
        rom[0] = OP_LOOP; rom[1] = OP_INC;
        bus.jump_fwd = 1'b1;
        do_reset();
        wait_valid(n);
        chk("um_first", bus.instr, 8'h5B);
        step(); step(); step();
        chk("um_addr2", bus.rom_addr, 2);
        chk("um_noerr", error, 1'b0);
        step();
        chk("um_noerr_chk", error, 1'b0);
        step();
        chk("um_err", error, 1'b1);
        chk("um_nohalt", halted, 1'b0);
        n = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.instr_valid) n++;
            step();
        end
        chk("um_novalid", n, 0);
        chk("um_err_sticky", error, 1'b1);

        // Restart from ERROR, then restart in the middle of a scan
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_err_clr", error, 1'b0);
        chk("rs_err_addr", bus.rom_addr, 0);
        wait_valid(n);
        chk("rs_err_lat", n, 2);
        chk("rs_err_instr", bus.instr, 8'h5B);
        step();
        chk("rs_scan_addr", bus.rom_addr, 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_scan_pc", bus.rom_addr, 0);
        chk("rs_scan_err", error, 1'b0);
        wait_valid(n);
        chk("rs_scan_lat", n, 2);
        chk("rs_scan_instr", bus.instr, 8'h5B);

        // Asynchronous reset mid-handshake
        bus.instr_ready = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        chk("ar_valid", bus.instr_valid, 1'b0);
        chk("ar_instr", bus.instr, 8'h00);
        chk("ar_addr", bus.rom_addr, 0);
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
